// File: rtl/cache_ticket_sched_pkg.sv
// Shared types and constants for the cache port-b ticket scheduler.
// Imported by the scheduler RTL.
package cache_ticket_sched_pkg;

  localparam int unsigned BURST_WORDS_W = 3;
  localparam int unsigned CACHE_N_BANKS = 4;
  // Lines moved per ticket; the cache's ticket protocol needs at least two.
  localparam int unsigned TICKET_BEATS  = (2 ** BURST_WORDS_W) / CACHE_N_BANKS;

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t IDLE  = 2'd0;
  localparam sched_state_t ISSUE = 2'd1;
  localparam sched_state_t HOLD  = 2'd2;

  typedef enum logic {
    TKT_FILL = 1'b0,
    TKT_WB   = 1'b1
  } tkt_class_t;

endpackage

// File: rtl/cache_ticket_sched_if.sv
// Cache-side ticket handshake: one request/ack/address triple for the wr-fifo
// (refill) and one for the rd-fifo (writeback).
interface cache_ticket_sched_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              ticket_rqst_wr;
  logic              ticket_ack_wr_fifo;
  logic [ADDR_W-1:0] wr_fifo_rqst_addr;
  logic              ticket_rqst_rd;
  logic              ticket_ack_rd_fifo;
  logic [ADDR_W-1:0] rd_fifo_rqst_addr;

  modport master (
    output ticket_rqst_wr,
    output wr_fifo_rqst_addr,
    output ticket_rqst_rd,
    output rd_fifo_rqst_addr,
    input  ticket_ack_wr_fifo,
    input  ticket_ack_rd_fifo
  );

  modport slave (
    input  ticket_rqst_wr,
    input  wr_fifo_rqst_addr,
    input  ticket_rqst_rd,
    input  rd_fifo_rqst_addr,
    output ticket_ack_wr_fifo,
    output ticket_ack_rd_fifo
  );

endinterface

// File: rtl/cache_ticket_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N.
module cache_ticket_sched_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cache_ticket_sched.sv
// Shares the cache port-b ticket interface between refill and writeback engines,
// one ticket at a time, with a bounded refill run while writebacks wait.
module cache_ticket_sched
  import cache_ticket_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned N_FILL     = 4,
  parameter int unsigned N_WB       = 4,
  parameter int unsigned HOLD_CYC   = 3,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N_FILL-1:0]        fill_req,
  input  logic [N_FILL*ADDR_W-1:0] fill_addr,
  output logic [N_FILL-1:0]        fill_gnt,
  input  logic [N_WB-1:0]          wb_req,
  input  logic [N_WB*ADDR_W-1:0]   wb_addr,
  output logic [N_WB-1:0]          wb_gnt,
  cache_ticket_sched_if.master     tkt,
  output logic                     busy,
  output logic                     spurious_ack
);

  localparam int unsigned FILL_IW = (N_FILL > 1) ? $clog2(N_FILL) : 1;
  localparam int unsigned WB_IW   = (N_WB > 1) ? $clog2(N_WB) : 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int unsigned CONS_W  = $clog2(MAX_CONSEC + 1);

  if (TICKET_BEATS < 2) begin : g_beats_check
    $error("TICKET_BEATS must be at least 2");
  end

  logic [ADDR_W-1:0] fill_addr_arr [N_FILL];
  logic [ADDR_W-1:0] wb_addr_arr   [N_WB];

  for (genvar g = 0; g < N_FILL; g++) begin : g_fill_addr
    assign fill_addr_arr[g] = fill_addr[g*ADDR_W +: ADDR_W];
  end
  for (genvar g = 0; g < N_WB; g++) begin : g_wb_addr
    assign wb_addr_arr[g] = wb_addr[g*ADDR_W +: ADDR_W];
  end

  sched_state_t       state_q, state_d;
  tkt_class_t         cls_q, cls_d;
  logic [FILL_IW-1:0] fill_sel_q, fill_sel_d;
  logic [WB_IW-1:0]   wb_sel_q, wb_sel_d;
  logic [FILL_IW-1:0] fill_ptr_q, fill_ptr_d;
  logic [WB_IW-1:0]   wb_ptr_q, wb_ptr_d;
  logic [CONS_W-1:0]  consec_q, consec_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rqst_wr_q, rqst_wr_d;
  logic               rqst_rd_q, rqst_rd_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [N_FILL-1:0]  fill_gnt_q, fill_gnt_d;
  logic [N_WB-1:0]    wb_gnt_q, wb_gnt_d;
  logic               spur_q, spur_d;
  logic               busy_q, busy_d;

  logic [FILL_IW-1:0] fill_win;
  logic [WB_IW-1:0]   wb_win;
  logic               fill_valid, wb_valid;

  cache_ticket_sched_rr_arbiter #(.N(N_FILL)) u_fill_arb (
    .req   (fill_req),
    .ptr   (fill_ptr_q),
    .idx   (fill_win),
    .valid (fill_valid)
  );

  cache_ticket_sched_rr_arbiter #(.N(N_WB)) u_wb_arb (
    .req   (wb_req),
    .ptr   (wb_ptr_q),
    .idx   (wb_win),
    .valid (wb_valid)
  );

  logic in_issue, issue_fill, issue_wb, ack_ok, spur_hit, pick_wb;

  always_comb begin
    in_issue   = (state_q == ISSUE);
    issue_fill = in_issue && (cls_q == TKT_FILL);
    issue_wb   = in_issue && (cls_q == TKT_WB);
    ack_ok     = (issue_fill && tkt.ticket_ack_wr_fifo) || (issue_wb && tkt.ticket_ack_rd_fifo);
    // An ack is only legitimate for the class currently being issued.
    spur_hit   = (tkt.ticket_ack_wr_fifo && !issue_fill) || (tkt.ticket_ack_rd_fifo && !issue_wb);
    pick_wb    = wb_valid && (!fill_valid || (consec_q == CONS_W'(MAX_CONSEC)));
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    fill_sel_d = fill_sel_q;
    wb_sel_d   = wb_sel_q;
    fill_ptr_d = fill_ptr_q;
    wb_ptr_d   = wb_ptr_q;
    hold_d     = hold_q;
    rqst_wr_d  = rqst_wr_q;
    rqst_rd_d  = rqst_rd_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    fill_gnt_d = '0;
    wb_gnt_d   = '0;
    spur_d     = spur_q | spur_hit;

    case (state_q)
      IDLE: begin
        if (fill_valid || wb_valid) begin
          state_d = ISSUE;
          if (pick_wb) begin
            cls_d     = TKT_WB;
            wb_sel_d  = wb_win;
            rd_addr_d = wb_addr_arr[wb_win];
            rqst_rd_d = 1'b1;
          end else begin
            cls_d      = TKT_FILL;
            fill_sel_d = fill_win;
            wr_addr_d  = fill_addr_arr[fill_win];
            rqst_wr_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ack_ok) begin
          state_d   = HOLD;
          hold_d    = '0;
          rqst_wr_d = 1'b0;
          rqst_rd_d = 1'b0;
          if (cls_q == TKT_FILL) begin
            fill_gnt_d[fill_sel_q] = 1'b1;
            fill_ptr_d = (fill_sel_q == FILL_IW'(N_FILL - 1)) ? '0 : fill_sel_q + 1'b1;
          end else begin
            wb_gnt_d[wb_sel_q] = 1'b1;
            wb_ptr_d = (wb_sel_q == WB_IW'(N_WB - 1)) ? '0 : wb_sel_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Run length of refill grants, counted only while some writeback is waiting.
  always_comb begin
    consec_d = consec_q;
    if (!wb_valid) begin
      consec_d = '0;
    end else if (ack_ok && (cls_q == TKT_WB)) begin
      consec_d = '0;
    end else if (ack_ok && (cls_q == TKT_FILL) && (consec_q != CONS_W'(MAX_CONSEC))) begin
      consec_d = consec_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cls_q      <= TKT_FILL;
      fill_sel_q <= '0;
      wb_sel_q   <= '0;
      fill_ptr_q <= '0;
      wb_ptr_q   <= '0;
      consec_q   <= '0;
      hold_q     <= '0;
      rqst_wr_q  <= 1'b0;
      rqst_rd_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      fill_gnt_q <= '0;
      wb_gnt_q   <= '0;
      spur_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      fill_sel_q <= fill_sel_d;
      wb_sel_q   <= wb_sel_d;
      fill_ptr_q <= fill_ptr_d;
      wb_ptr_q   <= wb_ptr_d;
      consec_q   <= consec_d;
      hold_q     <= hold_d;
      rqst_wr_q  <= rqst_wr_d;
      rqst_rd_q  <= rqst_rd_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      fill_gnt_q <= fill_gnt_d;
      wb_gnt_q   <= wb_gnt_d;
      spur_q     <= spur_d;
      busy_q     <= busy_d;
    end
  end

  assign tkt.ticket_rqst_wr    = rqst_wr_q;
  assign tkt.ticket_rqst_rd    = rqst_rd_q;
  assign tkt.wr_fifo_rqst_addr = wr_addr_q;
  assign tkt.rd_fifo_rqst_addr = rd_addr_q;
  assign fill_gnt              = fill_gnt_q;
  assign wb_gnt                = wb_gnt_q;
  assign busy                  = busy_q;
  assign spurious_ack          = spur_q;

endmodule

// File: tb/tb_cache_ticket_sched.sv
// Directed bench for cache_ticket_sched; the bench plays the cache and the engines.
module tb_cache_ticket_sched;

  localparam int unsigned AW = 16;
  localparam int unsigned NF = 4;
  localparam int unsigned NW = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NF-1:0]    fill_req = '0;
  logic [NF*AW-1:0] fill_addr = '0;
  logic [NF-1:0]    fill_gnt;
  logic [NW-1:0]    wb_req = '0;
  logic [NW*AW-1:0] wb_addr = '0;
  logic [NW-1:0]    wb_gnt;
  logic             busy;
  logic             spurious_ack;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  cache_ticket_sched_if #(.ADDR_W(AW)) tkt ();

  cache_ticket_sched dut (
    .clk          (clk),
    .nrst         (nrst),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_gnt     (fill_gnt),
    .wb_req       (wb_req),
    .wb_addr      (wb_addr),
    .wb_gnt       (wb_gnt),
    .tkt          (tkt),
    .busy         (busy),
    .spurious_ack (spurious_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tkt.ticket_rqst_wr && tkt.ticket_rqst_rd) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    fill_req = '0;
    wb_req = '0;
    tkt.ticket_ack_wr_fifo = 1'b0;
    tkt.ticket_ack_rd_fifo = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rqst", 32'({tkt.ticket_rqst_wr, tkt.ticket_rqst_rd}), 0);
    chk("rst_addr", 32'({tkt.wr_fifo_rqst_addr, tkt.rd_fifo_rqst_addr}), 0);
    chk("rst_gnt", 32'({fill_gnt, wb_gnt}), 0);
    chk("rst_spur", 32'(spurious_ack), 0);
    nrst = 1'b1;
  endtask

  // Waits for the request, acks it at once, checks the single grant pulse.
  task automatic run_ticket(input string tag, input bit is_wb, input int idx,
                            input logic [AW-1:0] addr, output int wait_n);
    int n;
    n = 0;
    while (!(is_wb ? tkt.ticket_rqst_rd : tkt.ticket_rqst_wr) && n < 20) begin
      tick();
      n++;
    end
    wait_n = n;
    chk({tag, "_rqst"}, 32'(is_wb ? tkt.ticket_rqst_rd : tkt.ticket_rqst_wr), 1);
    chk({tag, "_other_rqst"}, 32'(is_wb ? tkt.ticket_rqst_wr : tkt.ticket_rqst_rd), 0);
    chk({tag, "_addr"}, 32'(is_wb ? tkt.rd_fifo_rqst_addr : tkt.wr_fifo_rqst_addr),
        32'(addr));
    if (is_wb) tkt.ticket_ack_rd_fifo = 1'b1;
    else tkt.ticket_ack_wr_fifo = 1'b1;
    tick();
    tkt.ticket_ack_wr_fifo = 1'b0;
    tkt.ticket_ack_rd_fifo = 1'b0;
    chk({tag, "_gnt"}, 32'(is_wb ? wb_gnt : fill_gnt), 32'(1) << idx);
    chk({tag, "_gnt_other"}, 32'(is_wb ? fill_gnt : wb_gnt), 0);
    chk({tag, "_rqst_drop"}, 32'(tkt.ticket_rqst_wr | tkt.ticket_rqst_rd), 0);
    tick();
    chk({tag, "_gnt_pulse"}, 32'({fill_gnt, wb_gnt}), 0);
  endtask

  initial begin
    int w;
    int gcount;
    tkt.ticket_ack_wr_fifo = 1'b0;
    tkt.ticket_ack_rd_fifo = 1'b0;

    // 1. Single refill, address held through the hold window
    do_reset();
    fill_req = 4'b0010;
    fill_addr[1*AW +: AW] = 16'h002A;
    run_ticket("t1", 1'b0, 1, 16'h002A, w);
    fill_req = '0;
    chk("t1_wait", 32'(w), 1);
    chk("t1_hold_addr_c", 32'(tkt.wr_fifo_rqst_addr), 32'h2A);
    chk("t1_busy_c", 32'(busy), 1);
    tick();
    chk("t1_hold_addr_d", 32'(tkt.wr_fifo_rqst_addr), 32'h2A);
    chk("t1_rqst_d", 32'({tkt.ticket_rqst_wr, tkt.ticket_rqst_rd}), 0);
    tick();
    chk("t1_hold_addr_e", 32'(tkt.wr_fifo_rqst_addr), 32'h2A);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_spur", 32'(spurious_ack), 0);

    // 2. Round robin across four refill engines
    do_reset();
    for (int i = 0; i < 4; i++) fill_addr[i*AW +: AW] = AW'(16'h0010 + i);
    fill_req = 4'b1111;
    run_ticket("t2_g0", 1'b0, 0, 16'h0010, w);
    run_ticket("t2_g1", 1'b0, 1, 16'h0011, w);
    run_ticket("t2_g2", 1'b0, 2, 16'h0012, w);
    run_ticket("t2_g3", 1'b0, 3, 16'h0013, w);
    run_ticket("t2_g4", 1'b0, 0, 16'h0010, w);
    fill_req = '0;

    // 3. Starvation bound: four refills, then the writeback, twice over
    do_reset();
    for (int i = 0; i < 4; i++) fill_addr[i*AW +: AW] = AW'(16'h0020 + i);
    wb_addr[0 +: AW] = 16'h0077;
    fill_req = 4'b1111;
    wb_req = 4'b0001;
    for (int r = 0; r < 2; r++) begin
      run_ticket("t3_f0", 1'b0, 0, 16'h0020, w);
      run_ticket("t3_f1", 1'b0, 1, 16'h0021, w);
      run_ticket("t3_f2", 1'b0, 2, 16'h0022, w);
      run_ticket("t3_f3", 1'b0, 3, 16'h0023, w);
      run_ticket("t3_wb", 1'b1, 0, 16'h0077, w);
    end
    fill_req = '0;
    wb_req = '0;

    // 4. Cache withholds the ack for ten cycles
    do_reset();
    fill_addr[2*AW +: AW] = 16'h0055;
    fill_req = 4'b0100;
    tick();
    chk("t4_issue", 32'(tkt.ticket_rqst_wr), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stall_rqst", 32'(tkt.ticket_rqst_wr), 1);
      chk("t4_stall_addr", 32'(tkt.wr_fifo_rqst_addr), 32'h55);
      chk("t4_stall_busy", 32'(busy), 1);
      chk("t4_stall_gnt", 32'(fill_gnt), 0);
    end
    tkt.ticket_ack_wr_fifo = 1'b1;
    tick();
    tkt.ticket_ack_wr_fifo = 1'b0;
    fill_req = '0;
    chk("t4_gnt", 32'(fill_gnt), 32'h4);
    chk("t4_busy_hold", 32'(busy), 1);
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fill_gnt != '0) gcount++;
    end
    chk("t4_extra_gnts", 32'(gcount), 0);
    chk("t4_idle", 32'(busy), 0);

    // 5. Spurious ack while idle, then reset mid-ticket with a late ack
    do_reset();
    tkt.ticket_ack_rd_fifo = 1'b1;
    tick();
    tkt.ticket_ack_rd_fifo = 1'b0;
    chk("t5_spur_set", 32'(spurious_ack), 1);
    tick();
    chk("t5_spur_sticky", 32'(spurious_ack), 1);
    chk("t5_no_gnt", 32'({fill_gnt, wb_gnt}), 0);
    fill_addr[0 +: AW] = 16'h0099;
    fill_req = 4'b0001;
    tick();
    chk("t5_issue", 32'(tkt.ticket_rqst_wr), 1);
    nrst = 1'b0;
    tick();
    chk("t5_rst_rqst", 32'({tkt.ticket_rqst_wr, tkt.ticket_rqst_rd}), 0);
    chk("t5_rst_addr", 32'(tkt.wr_fifo_rqst_addr), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_spur", 32'(spurious_ack), 0);
    nrst = 1'b1;
    fill_req = '0;
    tkt.ticket_ack_wr_fifo = 1'b1;
    tick();
    tkt.ticket_ack_wr_fifo = 1'b0;
    chk("t5_late_gnt", 32'(fill_gnt), 0);
    chk("t5_late_spur", 32'(spurious_ack), 1);
    chk("t5_late_busy", 32'(busy), 0);
    tick();
    chk("t5_late_gnt2", 32'(fill_gnt), 0);

    // 6. Simultaneous refill and writeback with an empty refill run
    do_reset();
    fill_addr[0 +: AW] = 16'h0031;
    wb_addr[0 +: AW] = 16'h0042;
    fill_req = 4'b0001;
    wb_req = 4'b0001;
    run_ticket("t6_fill", 1'b0, 0, 16'h0031, w);
    fill_req = '0;
    run_ticket("t6_wb", 1'b1, 0, 16'h0042, w);
    wb_req = '0;
    chk("t6_wb_wait", 32'(w), 3);
    chk("t6_overlap", 32'(overlap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ticket_sched.md
Name: cache_ticket_sched

Overview:
Scheduler in front of the cache port-b ticket interface. Shares that interface between two requester classes:
- N_FILL refill engines, which write AXI read data into the cache via wr-fifo tickets.
- N_WB writeback engines, which read cache lines out to the AXI write path via rd-fifo tickets.

It grants one ticket at a time, holds the ticket address stable for the cache's sampling window, and bounds starvation between the two classes.

Parameters:
ADDR_W, M+L, cache line address width
N_FILL, 4, refill requesters
N_WB, 4, writeback requesters
HOLD_CYC, 3, cycles the address stays stable after ack (cache samples it 1–2 cycles late)
MAX_CONSEC, 4, max consecutive refill grants while any writeback is pending
TICKET_BEATS, 2**BURST_WORDS_W/CACHE_N_BANKS, lines per ticket; must be ≥2

Ports:
clk  in  1  clock
nrst  in  1  reset; synchronous, active-low
fill_req  in  N_FILL  level request per refill engine
fill_addr  in  N_FILL*ADDR_W  start line address per engine; engine i uses slice i
fill_gnt  out  N_FILL  one-cycle grant pulse
wb_req  in  N_WB  level request per writeback engine
wb_addr  in  N_WB*ADDR_W  start line address per engine
wb_gnt  out  N_WB  one-cycle grant pulse
ticket_rqst_wr  out  1  to cache (refill ticket)
ticket_ack_wr_fifo  in  1  from cache
wr_fifo_rqst_addr  out  ADDR_W  to cache
ticket_rqst_rd  out  1  to cache (writeback ticket)
ticket_ack_rd_fifo  in  1  from cache
rd_fifo_rqst_addr  out  ADDR_W  to cache
busy  out  1  state ≠ IDLE
spurious_ack  out  1  sticky; ack seen when not in ISSUE, or ack of the wrong class

Behaviour:
- Reset values: every output is 0. The FSM goes to IDLE. Both round-robin pointers reset to 0. consec_cnt resets to 0.
- All outputs are registered. No combinational path from input to output.

FSM states:
- IDLE:
  - If any fill_req or wb_req is high, pick the winner and latch its class, index and address.
  - Next state is ISSUE.
- ISSUE:
  - Drive the class-matching rqst high and the latched address on the class-matching addr port.
  - The other rqst stays 0. The two rqst outputs are never high together.
  - On the matching ack high: pulse gnt[index] for exactly one cycle (the cycle after the ack), drop rqst on the same edge, then go to HOLD.
- HOLD:
  - Keep the address stable and the rqst outputs at 0 for HOLD_CYC cycles.
  - Then return to IDLE. A new winner can issue no earlier than HOLD_CYC+1 cycles after the ack.

Class selection:
- Only one class pending: that class wins.
- Both classes pending: refill wins, unless consec_cnt == MAX_CONSEC, in which case writeback wins.
- consec_cnt increments on each refill grant made while wb_req≠0. It clears on any writeback grant, and also clears whenever wb_req==0.

Within a class:
- Round robin. Search starts at ptr and wraps modulo N.
- After a grant, ptr = index+1 mod N.

Requester rules:
- A requester must drop req the cycle after its gnt.
- A requester must hold its addr stable while req is high.
- If a latched requester deasserts req during ISSUE, the ticket still completes and the gnt is still pulsed. There is no abort.

Ack handling:
- An ack in any state other than ISSUE, or an ack of the non-matching class, is ignored and sets spurious_ack.
- spurious_ack clears only on reset.

Reset mid-ticket:
- Abandon the ticket immediately and drop rqst.
- A late ack arriving after reset is flagged through spurious_ack.

Address outputs:
- Unused address output keeps its last value.
- No arithmetic on addresses; the cache increments line addresses itself.

Decomposition:
- fcpu_pkg gets:
  - the state typedef `sched_state_t {IDLE, ISSUE, HOLD}`;
  - class enum `tkt_class_t {TKT_FILL, TKT_WB}`;
  - constant TICKET_BEATS, plus a static assertion that TICKET_BEATS ≥ 2.
- One sub-module, rr_arbiter: parameter N; inputs req[N], ptr; outputs idx, valid. It is combinational and is instantiated once per class.

Test Plan:
1. Single refill: fill_req=0010, fill_addr[1]=0x2A; cache acks one cycle after rqst.
   Required: ticket_rqst_wr high 1 cycle; fill_gnt=0010 for 1 cycle; wr_fifo_rqst_addr=0x2A held ≥ HOLD_CYC cycles; ticket_rqst_rd stays 0.
2. Round robin: fill_req=1111 held and re-asserted after each grant.
   Required: grant order 0,1,2,3,0; no requester granted twice in a row.
3. Starvation bound: fill_req=1111 continuous, wb_req=0001.
   Required: at most 4 refill grants, then wb_gnt=0001 with rd_fifo_rqst_addr=wb_addr[0]; consec_cnt then restarts.
4. Ack stall: cache withholds ack for 10 cycles.
   Required: rqst and address stable for all 10 cycles; exactly one gnt after the ack; busy=1 throughout.
5. Spurious and reset: ack_rd while idle → spurious_ack=1. Then nrst=0 during ISSUE → all outputs 0 next cycle. A late ack is ignored and no gnt is produced.
6. Simultaneous: fill_req=0001 and wb_req=0001 in the same cycle with consec_cnt=0.
   Required: refill is granted first; writeback issues after the HOLD period; the two rqst outputs are never high together.
